spi_reg_ctrl: RTL
=================

Name: spi_reg_ctrl

Overview:
- Protocol controller behind the byte-level `spi_slave`.
- Decodes SPI frames into accesses on a simple register bus: a command byte, then an auto-incrementing burst of writes or reads.
- Feeds read data back to the slave's TX load path with prefetch.
- Sits between `spi_slave` (rx/tx strobes, byte buses, spi_ss) and the HWAG register file.

Parameters:
- ADDR_W, 7, register address width; must be ≤7, taken from cmd bits [ADDR_W-1:0].
- RD_LATENCY, 1, cycles from bus_re to valid bus_rdata; legal range 1..3.
- STATUS, 8'hA5, byte returned during command and write phases.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- spi_ss  in  1  slave select, active-low; high = deselected / frame abort.
- rx  in  1  one-cycle strobe: slave received a byte.
- rx_data  in  8  received byte, valid while rx=1.
- tx  in  1  one-cycle strobe: slave loads tx_data into its shifter this cycle.
- tx_data  out  8  next byte to transmit.
- bus_addr  out  ADDR_W  register address.
- bus_wdata  out  8  write data.
- bus_we  out  1  one-cycle write strobe.
- bus_re  out  1  one-cycle read strobe.
- bus_rdata  in  8  read data, valid RD_LATENCY cycles after bus_re.
- busy  out  1  frame in progress.
- underrun  out  1  sticky: a TX load occurred with no read data ready.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: tx_data=STATUS, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, busy=0, underrun=0, state IDLE, internal addr=0, valid=0.
- Registered outputs: all outputs are registered.
- States: IDLE, CMD, WR, RD_ISSUE, RD_WAIT, RD_HOLD.
- Frame abort: spi_ss=1 forces IDLE on the next edge from any state.
  - No further bus ops are issued; an in-flight read result is discarded.
  - tx_data returns to STATUS.
  - spi_ss=1 wins over a simultaneous rx or tx.
- IDLE: busy=0. spi_ss=0 -> CMD, busy=1, underrun cleared.
- CMD: tx_data=STATUS. On rx: addr<=rx_data[ADDR_W-1:0]; rx_data[7]=1 -> RD_ISSUE, else -> WR.
- WR:
  - rx at cycle N -> in cycle N+1, bus_we=1, bus_addr=addr, bus_wdata=rx_data.
  - addr increments modulo 2^ADDR_W (7'h7F wraps to 0).
  - tx_data stays STATUS. Back-to-back rx on consecutive cycles must each produce a write.
- RD_ISSUE: bus_re=1 for exactly one cycle with bus_addr=addr; -> RD_WAIT.
- RD_WAIT: counts RD_LATENCY cycles, then captures bus_rdata into tx_data, sets valid, increments addr, -> RD_HOLD.
- Read latency: command rx at N -> bus_re at N+1 -> tx_data valid at N+2+RD_LATENCY.
- RD_HOLD: on tx, clears valid and -> RD_ISSUE (prefetch next address).
- tx_data in read states: 8'hFF whenever valid=0.
- TX load with valid=0 (in RD_ISSUE or RD_WAIT, including the capture cycle):
  - underrun<=1 and the slave loads 8'hFF.
  - The pending read still completes and is held for the next tx; no address is skipped.
- rx in read states: ignored (master dummy bytes).
- tx in CMD or WR: no state effect.
- Host timing rule: SPI half-period ≥ RD_LATENCY+3 clk, so the byte after the command is the first read data.
- rst mid-frame: immediate return to reset values. If spi_ss is still low, next cycle goes IDLE->CMD (the rest of the frame is treated as a new command).

Test Plan:
- Reset check: rst=1 two cycles, spi_ss=1 -> tx_data=8'hA5, bus_we=bus_re=busy=underrun=0.
- Write burst: spi_ss=0, rx 8'h10 then 8'h11, 8'h22, 8'h33 -> three bus_we pulses, each one cycle after its rx: (addr 10,11), (11,22), (12,33); tx_data stays A5.
- Read burst with wrap: spi_ss=0, rx 8'hFE, bus model returns addr^8'h5A at RD_LATENCY=1.
  - bus_re at addr 7E, tx_data=8'h24 three cycles after rx.
  - tx strobe -> bus_re at 7F, then tx_data=8'h25.
  - next tx -> bus_re at 00, then tx_data=8'h5A.
- Underrun: read command, assert tx one cycle after bus_re -> slave sees 8'hFF, underrun=1; next tx delivers the missed address's data; underrun clears only at the next frame start.
- Abort: spi_ss=1 in the same cycle as a write-phase rx -> no bus_we, IDLE next cycle, busy=0, tx_data=A5.
- Abort during RD_WAIT: no capture occurs.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI frame decoder: turns a command byte plus a burst of data bytes from the
// byte-level SPI slave into register-bus writes, or prefetched register reads.
module spi_reg_ctrl #(
  parameter int          ADDR_W     = 7,
  parameter int          RD_LATENCY = 1,
  parameter logic [7:0]  STATUS     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_ss,
  input  logic              rx,
  input  logic [7:0]        rx_data,
  input  logic              tx,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  output logic              busy,
  output logic              underrun,
  output logic [2:0]        fsm_state
);

  // Handshake: rx and tx are single-cycle strobes with no back-pressure; rx
  // qualifies rx_data for that cycle, and on tx the slave takes whatever
  // tx_data holds in that same cycle. bus_we/bus_re are single-cycle strobes
  // and bus_rdata is valid exactly RD_LATENCY cycles after bus_re.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WR       = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_HOLD  = 3'd5
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic [1:0]        lat_cnt;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      valid     <= 1'b0;
      lat_cnt   <= 2'd0;
      tx_data   <= STATUS;
      bus_addr  <= '0;
      bus_wdata <= 8'h00;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      bus_we <= 1'b0;
      bus_re <= 1'b0;
      // Deselect beats any strobe in the same cycle; an in-flight read is dropped.
      if (spi_ss) begin
        state   <= IDLE;
        busy    <= 1'b0;
        valid   <= 1'b0;
        lat_cnt <= 2'd0;
        tx_data <= STATUS;
      end else begin
        case (state)
          IDLE: begin
            state    <= CMD;
            busy     <= 1'b1;
            underrun <= 1'b0;
            tx_data  <= STATUS;
          end
          CMD: begin
            tx_data <= STATUS;
            if (rx) begin
              addr <= rx_data[ADDR_W-1:0];
              if (rx_data[7]) begin
                // First read goes out straight away so it beats the first TX load.
                state    <= RD_ISSUE;
                bus_re   <= 1'b1;
                bus_addr <= rx_data[ADDR_W-1:0];
                tx_data  <= 8'hFF;
                valid    <= 1'b0;
              end else begin
                state <= WR;
              end
            end
          end
          WR: begin
            if (rx) begin
              bus_we    <= 1'b1;
              bus_addr  <= addr;
              bus_wdata <= rx_data;
              addr      <= addr + 1'b1;
            end
          end
          RD_ISSUE: begin
            if (tx && !valid) underrun <= 1'b1;
            lat_cnt <= 2'd0;
            state   <= RD_WAIT;
          end
          RD_WAIT: begin
            // A load during the capture cycle still sees 8'hFF; the data is kept.
            if (tx && !valid) underrun <= 1'b1;
            if (lat_cnt == LAT_LAST) begin
              tx_data <= bus_rdata;
              valid   <= 1'b1;
              addr    <= addr + 1'b1;
              state   <= RD_HOLD;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          RD_HOLD: begin
            if (tx) begin
              valid    <= 1'b0;
              tx_data  <= 8'hFF;
              bus_re   <= 1'b1;
              bus_addr <= addr;
              state    <= RD_ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
